// File: rtl/memory_dma_multi.sv
// rtl/memory_dma_multi.sv - byte FIFO <-> MEM_BYTES-wide word memory DMA, big-endian lanes
// MEMORY_DMA_MULTI_COUNT_EN adds the transferred_count status output.
module memory_dma_multi #(
   parameter int MEM_BYTES = 2,
   parameter int ADDR_W    = 27,
   parameter int LEN_W     = 27
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   direction,
   input  logic [ADDR_W-1:0]      starting_address,
   input  logic [LEN_W-1:0]       transfer_length,
   output logic                   busy,
   input  logic                   rx_empty,
   output logic                   rx_read,
   input  logic [7:0]             rx_rdata,
   input  logic                   tx_full,
   output logic                   tx_write,
   output logic [7:0]             tx_wdata,
   output logic                   mem_request,
   input  logic                   mem_ack,
   output logic                   mem_write,
   output logic [ADDR_W-1:0]      mem_address,
   output logic [MEM_BYTES-1:0]   mem_wmask,
   output logic [8*MEM_BYTES-1:0] mem_wdata,
   input  logic [8*MEM_BYTES-1:0] mem_rdata
`ifdef MEMORY_DMA_MULTI_COUNT_EN
   ,
   output logic [LEN_W-1:0]       transferred_count
`endif
);
   localparam int LW = $clog2(MEM_BYTES);
   localparam int PW = LW + 1;

   typedef enum logic [2:0] {IDLE, RX_FILL, RX_WRITE, TX_FETCH, TX_DRAIN, ABORT} state_t;

   state_t                 state_q, state_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [PW-1:0]          lane_q, lane_d;
   logic [LEN_W-1:0]       rem_q, rem_d;
   logic [8*MEM_BYTES-1:0] data_q, data_d;
   logic [MEM_BYTES-1:0]   wmask_q, wmask_d;
   logic                   req_q, req_d, wr_q, wr_d, pend_q, pend_d, busy_q;
   logic                   accept;
   int                     lane_idx;

   assign accept = start && !stop && (state_q == IDLE) && (transfer_length != '0);

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      lane_d   = lane_q;
      rem_d    = rem_q;
      data_d   = data_q;
      wmask_d  = wmask_q;
      req_d    = req_q;
      wr_d     = wr_q;
      pend_d   = 1'b0;
      rx_read  = 1'b0;
      tx_write = 1'b0;
      // byte offset o within the word lives in lane MEM_BYTES-1-o
      lane_idx = MEM_BYTES - 1 - int'(lane_q[LW-1:0]);
      tx_wdata = data_q[8*lane_idx +: 8];
      case (state_q)
         IDLE: if (accept) begin
            wr_d    = direction;
            addr_d  = {starting_address[ADDR_W-1:LW], {LW{1'b0}}};
            lane_d  = {1'b0, starting_address[LW-1:0]};
            rem_d   = transfer_length;
            data_d  = '0;
            wmask_d = '0;
            state_d = direction ? RX_FILL : TX_FETCH;
            req_d   = !direction;
         end
         RX_FILL: begin
            // pend_q marks the pop issued last cycle whose byte is on rx_rdata now
            rx_read = (rem_q != '0) && !rx_empty && !stop &&
                      ((lane_q + PW'(pend_q)) < PW'(MEM_BYTES));
            pend_d  = rx_read;
            rem_d   = rem_q - LEN_W'(rx_read);
            if (pend_q) begin
               data_d[8*lane_idx +: 8] = rx_rdata;
               wmask_d[lane_idx]       = 1'b1;
               lane_d                  = lane_q + PW'(1);
            end
            if ((lane_d == PW'(MEM_BYTES)) || ((rem_d == '0) && !rx_read)) begin
               state_d = RX_WRITE;
               req_d   = 1'b1;
            end
         end
         RX_WRITE: if (mem_ack) begin
            req_d   = 1'b0;
            addr_d  = addr_q + ADDR_W'(MEM_BYTES);
            lane_d  = '0;
            wmask_d = '0;
            data_d  = '0;
            state_d = (rem_q != '0) ? RX_FILL : IDLE;
         end
         TX_FETCH: if (mem_ack) begin
            data_d  = mem_rdata;
            req_d   = 1'b0;
            state_d = TX_DRAIN;
         end
         TX_DRAIN: begin
            tx_write = !tx_full && !stop;
            if (tx_write) begin
               rem_d  = rem_q - LEN_W'(1);
               lane_d = lane_q + PW'(1);
               if (rem_d == '0) begin
                  state_d = IDLE;
               end else if (lane_q == PW'(MEM_BYTES - 1)) begin
                  addr_d  = addr_q + ADDR_W'(MEM_BYTES);
                  lane_d  = '0;
                  state_d = TX_FETCH;
                  req_d   = 1'b1;
               end
            end
         end
         ABORT: if (mem_ack) begin
            req_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // abort: an open bus cycle must still be closed by its ack, its result is dropped
      if (stop && (state_q != IDLE)) begin
         rem_d   = '0;
         pend_d  = 1'b0;
         data_d  = data_q;
         wmask_d = wmask_q;
         addr_d  = addr_q;
         if (req_q && !mem_ack) begin
            state_d = ABORT;
            req_d   = 1'b1;
         end else begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         lane_q  <= '0;
         rem_q   <= '0;
         data_q  <= '0;
         wmask_q <= '0;
         req_q   <= 1'b0;
         wr_q    <= 1'b0;
         pend_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         lane_q  <= lane_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         wmask_q <= wmask_d;
         req_q   <= req_d;
         wr_q    <= wr_d;
         pend_q  <= pend_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   assign busy        = busy_q;
   assign mem_request = req_q;
   assign mem_write   = wr_q;
   assign mem_address = addr_q;
   assign mem_wmask   = wmask_q;
   assign mem_wdata   = data_q;

`ifdef MEMORY_DMA_MULTI_COUNT_EN
   logic [LEN_W-1:0] cnt_q, cnt_d;

   function automatic logic [LEN_W-1:0] ones(input logic [MEM_BYTES-1:0] m);
      logic [LEN_W-1:0] n;
      n = '0;
      for (int i = 0; i < MEM_BYTES; i++) n = n + LEN_W'(m[i]);
      return n;
   endfunction

   always_comb begin
      cnt_d = cnt_q;
      if (accept)
         cnt_d = '0;
      else if (tx_write)
         cnt_d = cnt_q + LEN_W'(1);
      else if ((state_q == RX_WRITE) && mem_ack && !stop)
         cnt_d = cnt_q + ones(wmask_q);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign transferred_count = cnt_q;
`endif
endmodule

// File: tb/tb_memory_dma_multi.sv
// tb/tb_memory_dma_multi.sv - randomized self-checking bench for memory_dma_multi (MEM_BYTES=4)
module tb_memory_dma_multi;
   localparam int MB = 4;
   localparam int AW = 12;
   localparam int LW = 12;

   logic          clk, reset_n, start, stop, direction, busy;
   logic [AW-1:0] starting_address, mem_address;
   logic [LW-1:0] transfer_length;
   logic          rx_empty, rx_read, tx_full, tx_write, mem_request, mem_ack, mem_write;
   logic [7:0]    rx_rdata, tx_wdata;
   logic [MB-1:0] mem_wmask;
   logic [31:0]   mem_wdata, mem_rdata;
`ifdef MEMORY_DMA_MULTI_COUNT_EN
   logic [LW-1:0] transferred_count;
`endif

   memory_dma_multi #(.MEM_BYTES(MB), .ADDR_W(AW), .LEN_W(LW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .direction(direction),
      .starting_address(starting_address), .transfer_length(transfer_length), .busy(busy),
      .rx_empty(rx_empty), .rx_read(rx_read), .rx_rdata(rx_rdata),
      .tx_full(tx_full), .tx_write(tx_write), .tx_wdata(tx_wdata),
      .mem_request(mem_request), .mem_ack(mem_ack), .mem_write(mem_write),
      .mem_address(mem_address), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
`ifdef MEMORY_DMA_MULTI_COUNT_EN
      , .transferred_count(transferred_count)
`endif
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   int n_cmp = 0, n_bad = 0;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [7:0]  bmem [4096];
   logic [7:0]  exp_img [4096];
   logic [7:0]  src_q[$], got_q[$], exp_tx[$];
   logic [11:0] rlog[$], wlog_a[$];
   logic [3:0]  wlog_m[$];
   logic [31:0] wlog_d[$];
   int  pops, viol, req_drop, late_act, req_in_full, wait_cnt, ack_force;
   bit  stall_en, force_full, after_stop, req_pending, ev_pop;
   logic [7:0] next_rdata;

   function automatic logic [31:0] rd_word(input logic [11:0] a);
      logic [31:0] w;
      for (int i = 0; i < MB; i++) w[8*i +: 8] = bmem[a + 12'(MB - 1 - i)];
      return w;
   endfunction

   function automatic logic [63:0] out_vec();
      return 64'({busy, rx_read, tx_write, mem_request, mem_write, mem_address,
                  mem_wmask, mem_wdata, tx_wdata});
   endfunction

   // FIFO and memory environment: handshakes judged at negedge, inputs changed after posedge
   initial begin : env
      forever begin
         @(negedge clk);
         ev_pop = 0;
         if (!reset_n) begin
            req_pending = 0;
         end else begin
            if (rx_read) begin
               if (rx_empty || src_q.size() == 0) viol++;
               else begin
                  next_rdata = src_q.pop_front();
                  ev_pop = 1;
                  pops++;
                  if (after_stop) late_act++;
               end
            end
            if (tx_write) begin
               if (tx_full) viol++;
               else begin
                  got_q.push_back(tx_wdata);
                  if (after_stop) late_act++;
               end
            end
            if (req_pending && !mem_request) req_drop++;
            if (mem_request) begin
               if (mem_address[1:0] != 2'b00) viol++;
               if (force_full && tx_full) req_in_full++;
               if (mem_ack) begin
                  if (mem_write) begin
                     wlog_a.push_back(mem_address);
                     wlog_m.push_back(mem_wmask);
                     wlog_d.push_back(mem_wdata);
                     for (int i = 0; i < MB; i++)
                        if (mem_wmask[i]) bmem[mem_address + 12'(MB - 1 - i)] = mem_wdata[8*i +: 8];
                  end else begin
                     rlog.push_back(mem_address);
                  end
               end
            end
            req_pending = mem_request && !mem_ack;
         end
         @(posedge clk);
         #1;
         rx_rdata = ev_pop ? next_rdata : 8'($urandom);
         rx_empty = (src_q.size() == 0) || (stall_en && $urandom_range(0, 3) == 0);
         tx_full  = force_full || (stall_en && $urandom_range(0, 3) == 0);
         if (mem_ack) begin
            mem_ack  = 0;
            wait_cnt = (ack_force >= 0) ? ack_force : (stall_en ? int'($urandom_range(0, 3)) : 0);
         end else if (mem_request) begin
            if (wait_cnt <= 0) begin
               mem_ack   = 1;
               mem_rdata = rd_word(mem_address);
            end else begin
               wait_cnt--;
            end
         end
      end
   end

   task automatic clear_logs();
      got_q.delete(); rlog.delete(); wlog_a.delete(); wlog_m.delete(); wlog_d.delete();
      src_q.delete(); pops = 0;
   endtask

   task automatic pulse(input logic st, input logic sp, input logic dir,
                        input logic [11:0] a, input logic [11:0] l);
      @(posedge clk); #1;
      start = st; stop = sp; direction = dir; starting_address = a; transfer_length = l;
      @(posedge clk); #1;
      start = 0; stop = 0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (busy && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_done"}, 64'(busy), 64'd0);
   endtask

   task automatic check_tx(input string tag);
      int mism = 0;
      check({tag, "_nbytes"}, 64'(got_q.size()), 64'(exp_tx.size()));
      for (int k = 0; k < exp_tx.size() && k < got_q.size(); k++)
         if (got_q[k] !== exp_tx[k]) mism++;
      check({tag, "_bytes"}, 64'(mism), 64'd0);
   endtask

   task automatic run_random();
      logic dir;
      logic [11:0] a, l;
      logic [7:0] b;
      int nw, mism;
      dir = 1'($urandom);
      a = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(4080, 4095)) : 12'($urandom);
      l = 12'($urandom_range(1, 20));
      clear_logs();
      exp_tx.delete();
      if (dir) begin
         exp_img = bmem;
         for (int k = 0; k < int'(l); k++) begin
            b = 8'($urandom);
            src_q.push_back(b);
            exp_img[12'(int'(a) + k)] = b;
         end
      end else begin
         for (int k = 0; k < int'(l); k++) exp_tx.push_back(bmem[12'(int'(a) + k)]);
      end
      nw = (int'(a) % MB + int'(l) - 1) / MB + 1;
      pulse(1, 0, dir, a, l);
      wait_done("rnd");
      if (dir) begin
         mism = 0;
         for (int i = 0; i < 4096; i++) if (bmem[i] !== exp_img[i]) mism++;
         check("rnd_rx_image", 64'(mism), 64'd0);
         check("rnd_rx_pops", 64'(pops), 64'(l));
         check("rnd_rx_writes", 64'(wlog_a.size()), 64'(nw));
      end else begin
         check_tx("rnd_tx");
         check("rnd_tx_reads", 64'(rlog.size()), 64'(nw));
      end
`ifdef MEMORY_DMA_MULTI_COUNT_EN
      check("rnd_count", 64'(transferred_count), 64'(l));
`endif
   endtask

   initial begin : main
      int n;
      reset_n = 0; start = 0; stop = 0; direction = 0; starting_address = 0; transfer_length = 0;
      rx_empty = 1; rx_rdata = 0; tx_full = 0; mem_ack = 0; mem_rdata = 0;
      stall_en = 0; force_full = 0; after_stop = 0; ack_force = -1; wait_cnt = 0;
      viol = 0; req_drop = 0; late_act = 0; req_in_full = 0;
      for (int i = 0; i < 4096; i++) bmem[i] = 8'($urandom);
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", out_vec(), 64'd0);
      reset_n = 1;

      // rx at 0x101, 6 bytes: two partial-mask writes
      clear_logs();
      for (int k = 0; k < 6; k++) src_q.push_back(8'(8'hA1 + k));
      pulse(1, 0, 1, 12'h101, 12'd6);
      check("t1_busy", 64'(busy), 64'd1);
      wait_done("t1");
      check("t1_nwrites", 64'(wlog_a.size()), 64'd2);
      if (wlog_a.size() >= 2) begin
         check("t1_addr0", 64'(wlog_a[0]), 64'h100);
         check("t1_mask0", 64'(wlog_m[0]), 64'b0111);
         check("t1_data0", 64'(wlog_d[0]), 64'h00A1A2A3);
         check("t1_addr1", 64'(wlog_a[1]), 64'h104);
         check("t1_mask1", 64'(wlog_m[1]), 64'b1110);
         check("t1_data1", 64'(wlog_d[1]), 64'hA4A5A600);
      end
`ifdef MEMORY_DMA_MULTI_COUNT_EN
      check("t1_count", 64'(transferred_count), 64'd6);
`endif

      // tx at 0x3, 3 bytes spanning two words
      clear_logs();
      for (int i = 0; i < 8; i++) bmem[i] = 8'(8'h11 * (i + 1));
      exp_tx = '{8'h44, 8'h55, 8'h66};
      pulse(1, 0, 0, 12'h003, 12'd3);
      wait_done("t2");
      check_tx("t2");
      check("t2_nreads", 64'(rlog.size()), 64'd2);
      if (rlog.size() >= 2) begin
         check("t2_raddr0", 64'(rlog[0]), 64'h000);
         check("t2_raddr1", 64'(rlog[1]), 64'h004);
      end
`ifdef MEMORY_DMA_MULTI_COUNT_EN
      check("t2_count", 64'(transferred_count), 64'd3);
`endif

      // tx_full held for 5 cycles mid-drain
      clear_logs();
      exp_tx.delete();
      for (int k = 0; k < 10; k++) exp_tx.push_back(bmem[12'h010 + 12'(k)]);
      pulse(1, 0, 0, 12'h010, 12'd10);
      n = 0;
      while (got_q.size() < 2 && n < 200) begin @(posedge clk); #1; n++; end
      check("t3_reach_drain", 64'(got_q.size() >= 2), 64'd1);
      force_full = 1;
      repeat (5) @(posedge clk);
      #1;
      force_full = 0;
      wait_done("t3");
      check_tx("t3");
      check("t3_nreads", 64'(rlog.size()), 64'd3);
      check("t3_req_while_full", 64'(req_in_full), 64'd0);

      // stop while a write request waits 4 cycles for its ack
      clear_logs();
      for (int k = 0; k < 8; k++) src_q.push_back(8'($urandom));
      ack_force = 4; wait_cnt = 4;
      pulse(1, 0, 1, 12'h200, 12'd8);
      n = 0;
      while (!mem_request && n < 200) begin @(posedge clk); #1; n++; end
      check("t4_req_seen", 64'(mem_request), 64'd1);
      stop = 1;
      @(posedge clk); #1;
      stop = 0; after_stop = 1;
      check("t4_req_held", 64'(mem_request), 64'd1);
      check("t4_busy_held", 64'(busy), 64'd1);
      wait_done("t4");
      repeat (4) @(posedge clk);
      #1;
      check("t4_req_after", 64'(mem_request), 64'd0);
      check("t4_late_fifo", 64'(late_act), 64'd0);
      check("t4_pops", 64'(pops), 64'd4);
      after_stop = 0; ack_force = -1; wait_cnt = 0;

      // ignored starts
      clear_logs();
      pulse(1, 0, 1, 12'h080, 12'd0);
      check("t5_len0_busy", 64'(busy), 64'd0);
      pulse(1, 1, 0, 12'h080, 12'd4);
      check("t5_startstop_busy", 64'(busy), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("t5_no_req", 64'(rlog.size() + wlog_a.size() + int'(mem_request)), 64'd0);
      exp_tx.delete();
      for (int k = 0; k < 6; k++) exp_tx.push_back(bmem[12'h040 + 12'(k)]);
      pulse(1, 0, 0, 12'h040, 12'd6);
      pulse(1, 0, 1, 12'h080, 12'd5);
      wait_done("t5");
      check_tx("t5");
      check("t5_no_writes", 64'(wlog_a.size()), 64'd0);
      check("t5_nreads", 64'(rlog.size()), 64'd2);

      // reset in the middle of a write request
      clear_logs();
      for (int k = 0; k < 8; k++) src_q.push_back(8'($urandom));
      ack_force = 50; wait_cnt = 50;
      pulse(1, 0, 1, 12'h300, 12'd8);
      n = 0;
      while (!(mem_request && mem_write) && n < 200) begin @(posedge clk); #1; n++; end
      check("t6_in_write", 64'(mem_request && mem_write), 64'd1);
      reset_n = 0;
      @(posedge clk); #1;
      check("t6_reset_outputs", out_vec(), 64'd0);
`ifdef MEMORY_DMA_MULTI_COUNT_EN
      check("t6_reset_count", 64'(transferred_count), 64'd0);
`endif
      reset_n = 1;
      ack_force = -1; wait_cnt = 0;
      clear_logs();

      stall_en = 1;
      for (int t = 0; t < 40; t++) run_random();
      stall_en = 0;

      check("protocol_violations", 64'(viol), 64'd0);
      check("request_dropped", 64'(req_drop), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
